decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 172 +++++++++++++++++
 tb/tb_decode_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: splits the fetched instruction into register selects, immediate
// and destination, forwards operands from EX/MEM, and detects load-use hazards.
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] insn_in,
  input  logic [31:0] pc_in,
  input  logic        valid_in,
  output logic        stall_out,
  output logic [4:0]  s1,
  output logic [4:0]  s2,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] alu_result,
  input  logic [4:0]  mem_d,
  input  logic        mem_we,
  input  logic [31:0] mem_data,
  input  logic        hold_in,
  input  logic        flush_in,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_insn,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic        ex_we,
  output logic        ex_load
);

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_IMM,
    CLS_LOAD,
    CLS_SRC2,
    CLS_NONE
  } cls_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        we;
    logic        load;
  } ex_t;

  ex_t         ex_q, ex_d;
  cls_e        cls;
  logic [5:0]  opcode;
  logic [4:0]  dec_dest;
  logic        uses_rs, uses_rt, is_load;
  logic [31:0] dec_imm;
  logic [31:0] opa, opb;
  logic        hazard;

  assign opcode = insn_in[31:26];
  assign s1     = insn_in[25:21];
  assign s2     = insn_in[20:16];

  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      6'h00:                             cls = CLS_RTYPE;
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F: cls = CLS_IMM;
      6'h23:                             cls = CLS_LOAD;
      6'h2B, 6'h04, 6'h05:               cls = CLS_SRC2;
      default:                           cls = CLS_NONE;
    endcase
  end

  always_comb begin
    dec_dest = '0;
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    is_load  = 1'b0;
    case (cls)
      CLS_RTYPE: begin
        dec_dest = insn_in[15:11];
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
      end
      CLS_IMM: begin
        dec_dest = insn_in[20:16];
        uses_rs  = 1'b1;
      end
      CLS_LOAD: begin
        dec_dest = insn_in[20:16];
        uses_rs  = 1'b1;
        is_load  = 1'b1;
      end
      CLS_SRC2: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      6'h0C, 6'h0D: dec_imm = {16'h0000, insn_in[15:0]};
      6'h0F:        dec_imm = {insn_in[15:0], 16'h0000};
      default:      dec_imm = {{16{insn_in[15]}}, insn_in[15:0]};
    endcase
  end

  // A load in EX has no result yet, so it is never a forwarding source.
  function automatic logic [31:0] fwd(input logic [4:0]  field,
                                      input logic [31:0] rf_val,
                                      input ex_t         ex,
                                      input logic [31:0] alu,
                                      input logic [4:0]  md,
                                      input logic        mwe,
                                      input logic [31:0] mdata);
    if (field == 5'd0)                                        return '0;
    else if (ex.valid && ex.we && !ex.load && ex.dest == field) return alu;
    else if (mwe && md == field)                                return mdata;
    else                                                        return rf_val;
  endfunction

  always_comb begin
    opa = fwd(s1, rs_data, ex_q, alu_result, mem_d, mem_we, mem_data);
    opb = fwd(s2, rt_data, ex_q, alu_result, mem_d, mem_we, mem_data);
  end

  always_comb begin
    hazard = valid_in && ex_q.valid && ex_q.load && (ex_q.dest != 5'd0) &&
             ((uses_rs && ex_q.dest == s1) || (uses_rt && ex_q.dest == s2));
    stall_out = (hold_in || hazard) && !flush_in;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush_in) begin
      ex_d = '0;
    end else if (hold_in) begin
      ex_d = ex_q;
    end else if (hazard || !valid_in) begin
      ex_d = '0;
    end else begin
      ex_d.valid = 1'b1;
      ex_d.pc    = pc_in;
      ex_d.insn  = insn_in;
      ex_d.a     = opa;
      ex_d.b     = opb;
      ex_d.imm   = dec_imm;
      ex_d.dest  = dec_dest;
      ex_d.we    = (dec_dest != 5'd0);
      ex_d.load  = is_load;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ex_valid = ex_q.valid;
  assign ex_pc    = ex_q.pc;
  assign ex_insn  = ex_q.insn;
  assign ex_a     = ex_q.a;
  assign ex_b     = ex_q.b;
  assign ex_imm   = ex_q.imm;
  assign ex_dest  = ex_q.dest;
  assign ex_we    = ex_q.we;
  assign ex_load  = ex_q.load;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected EX-register contents are queued as
// each instruction is presented and compared one cycle later.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_in, pc_in;
  logic        valid_in;
  logic        stall_out;
  logic [4:0]  s1, s2;
  logic [31:0] rs_data, rt_data, alu_result;
  logic [4:0]  mem_d;
  logic        mem_we;
  logic [31:0] mem_data;
  logic        hold_in, flush_in;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_insn, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_dest;
  logic        ex_we, ex_load;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [167:0] v;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  decode_stage dut (
    .clock(clock), .reset(reset), .insn_in(insn_in), .pc_in(pc_in),
    .valid_in(valid_in), .stall_out(stall_out), .s1(s1), .s2(s2),
    .rs_data(rs_data), .rt_data(rt_data), .alu_result(alu_result),
    .mem_d(mem_d), .mem_we(mem_we), .mem_data(mem_data),
    .hold_in(hold_in), .flush_in(flush_in), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_insn(ex_insn), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_we(ex_we), .ex_load(ex_load)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [167:0] mk(logic v, logic we, logic ld, logic [4:0] d,
                                      logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                      logic [31:0] pc, logic [31:0] insn);
    return {v, we, ld, d, a, b, imm, pc, insn};
  endfunction

  function automatic logic [167:0] pack_out();
    return {ex_valid, ex_we, ex_load, ex_dest, ex_a, ex_b, ex_imm, ex_pc, ex_insn};
  endfunction

  task automatic drive(logic [31:0] insn, logic [31:0] pc, logic v, logic [31:0] rs, logic [31:0] rt);
    insn_in  = insn;
    pc_in    = pc;
    valid_in = v;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  task automatic push(string name, logic [167:0] v);
    exp_t x;
    x.name = name;
    x.v    = v;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b1; hold_in = 1'b0; flush_in = 1'b0;
    alu_result = '0; mem_d = '0; mem_we = 1'b0; mem_data = '0;
    drive(rtype(1, 2, 3, 6'h21), 32'h40, 1'b1, 32'h5, 32'h7);
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (pack_out() !== '0) begin errors++; $display("FAIL reset_regs got=%h exp=0", pack_out()); end
    hold_in = 1'b1; #1;
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL reset_stall_hold got=%b exp=1", stall_out); end
    hold_in = 1'b0; #1;
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got=%b exp=0", stall_out); end
    reset = 1'b0;
  endtask

  task automatic test_addu();
    logic [31:0] i;
    i = rtype(1, 2, 3, 6'h21);
    drive(i, 32'h100, 1'b1, 32'd5, 32'd7); #1;
    checks++;
    if (s1 !== 5'd1 || s2 !== 5'd2) begin errors++; $display("FAIL selects got=%0d/%0d exp=1/2", s1, s2); end
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL addu_stall got=%b exp=0", stall_out); end
    push("addu", mk(1, 1, 0, 3, 5, 7, 32'h1821, 32'h100, i));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
  endtask

  task automatic test_forward();
    logic [31:0] i;
    i = itype(6'h08, 1, 4, 16'h0001);
    drive(i, 32'h104, 1'b1, 32'd9, 32'h77);
    push("addi_r4", mk(1, 1, 0, 4, 9, 32'h77, 1, 32'h104, i));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    i = rtype(4, 4, 5, 6'h20);
    drive(i, 32'h108, 1'b1, 32'hDEAD, 32'hDEAD);
    alu_result = 32'h10; mem_d = 5'd4; mem_we = 1'b1; mem_data = 32'h20;
    push("fwd_ex_over_mem", mk(1, 1, 0, 5, 32'h10, 32'h10, 32'h2820, 32'h108, i));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    i = rtype(4, 0, 6, 6'h21);
    drive(i, 32'h10C, 1'b1, 32'hDEAD, 32'hDEAD);
    push("fwd_mem_zero", mk(1, 1, 0, 6, 32'h20, 0, 32'h3021, 32'h10C, i));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    mem_we = 1'b0;
  endtask

  task automatic test_load_use();
    logic [31:0] lw6, u, i;
    lw6 = itype(6'h23, 1, 6, 16'h0008);
    u   = rtype(6, 0, 7, 6'h21);
    drive(rtype(6, 6, 6, 6'h21), 32'h1FC, 1'b0, 32'h1, 32'h1);
    push("invalid_bubble", '0);
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(lw6, 32'h200, 1'b1, 32'h1000, 32'h55);
    push("lw_r6", mk(1, 1, 1, 6, 32'h1000, 32'h55, 8, 32'h200, lw6));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(u, 32'h204, 1'b1, 32'h1, 32'h0); #1;
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL loaduse_stall got=%b exp=1", stall_out); end
    push("loaduse_bubble", '0);
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    alu_result = 32'h999; mem_d = 5'd6; mem_we = 1'b1; mem_data = 32'hABCD; #1;
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL loaduse_release got=%b exp=0", stall_out); end
    push("loaduse_issue", mk(1, 1, 0, 7, 32'hABCD, 0, 32'h3821, 32'h204, u));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    mem_we = 1'b0;
    i = itype(6'h23, 1, 0, 16'h0010);
    drive(i, 32'h208, 1'b1, 32'h2000, 32'h55);
    push("lw_r0", mk(1, 0, 1, 0, 32'h2000, 0, 32'h10, 32'h208, i));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    i = rtype(0, 0, 9, 6'h21);
    drive(i, 32'h20C, 1'b1, 32'h3, 32'h3); #1;
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL lw_r0_nostall got=%b exp=0", stall_out); end
    push("after_lw_r0", mk(1, 1, 0, 9, 0, 0, 32'h4821, 32'h20C, i));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(lw6, 32'h210, 1'b1, 32'h1000, 32'h55);
    push("lw_r6_b", mk(1, 1, 1, 6, 32'h1000, 32'h55, 8, 32'h210, lw6));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(u, 32'h214, 1'b0, 32'h1, 32'h0); #1;
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL invalid_no_hazard got=%b exp=0", stall_out); end
    push("invalid_after_lw", '0);
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(lw6, 32'h218, 1'b1, 32'h1000, 32'h55);
    push("lw_r6_c", mk(1, 1, 1, 6, 32'h1000, 32'h55, 8, 32'h218, lw6));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    i = itype(6'h08, 1, 6, 16'h0001);
    drive(i, 32'h21C, 1'b1, 32'h3, 32'h44); #1;
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL rt_is_dest_nostall got=%b exp=0", stall_out); end
    push("addi_after_lw", mk(1, 1, 0, 6, 3, 32'h44, 1, 32'h21C, i));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
  endtask

  task automatic test_imm();
    logic [31:0] ins [7];
    logic [167:0] ex [7];
    string nm [7];
    ins[0] = rtype(1, 1, 0, 6'h21);            nm[0] = "addu_r0";
    ex[0]  = mk(1, 0, 0, 0, 32'h11, 32'h11, 32'h0021, 32'h300, ins[0]);
    ins[1] = itype(6'h0D, 0, 8, 16'hFFFF);     nm[1] = "ori_zext";
    ex[1]  = mk(1, 1, 0, 8, 0, 32'h22, 32'h0000FFFF, 32'h304, ins[1]);
    ins[2] = itype(6'h08, 2, 9, 16'hFFFF);     nm[2] = "addi_sext";
    ex[2]  = mk(1, 1, 0, 9, 32'h11, 32'h22, 32'hFFFFFFFF, 32'h308, ins[2]);
    ins[3] = itype(6'h0F, 0, 10, 16'h1234);    nm[3] = "lui";
    ex[3]  = mk(1, 1, 0, 10, 0, 32'h22, 32'h12340000, 32'h30C, ins[3]);
    ins[4] = itype(6'h2B, 1, 3, 16'hFFFC);     nm[4] = "sw_nodest";
    ex[4]  = mk(1, 0, 0, 0, 32'h11, 32'h22, 32'hFFFFFFFC, 32'h310, ins[4]);
    ins[5] = itype(6'h3F, 1, 2, 16'h8000);     nm[5] = "unknown_op";
    ex[5]  = mk(1, 0, 0, 0, 32'h11, 32'h22, 32'hFFFF8000, 32'h314, ins[5]);
    ins[6] = itype(6'h0C, 1, 11, 16'h8000);    nm[6] = "andi_zext";
    ex[6]  = mk(1, 1, 0, 11, 32'h11, 32'h22, 32'h00008000, 32'h318, ins[6]);
    for (int k = 0; k < 7; k++) begin
      drive(ins[k], 32'h300 + 32'(4 * k), 1'b1, (k == 0) ? 32'h11 : 32'h11, (k == 0) ? 32'h11 : 32'h22);
      push(nm[k], ex[k]);
      @(posedge clock); #1; e = sb.pop_front(); checks++;
      if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    end
  endtask

  task automatic test_hold_flush();
    logic [31:0] lw6, x;
    lw6 = itype(6'h23, 1, 6, 16'h0008);
    x   = rtype(1, 2, 3, 6'h21);
    drive(lw6, 32'h400, 1'b1, 32'h1000, 32'h55);
    push("hf_lw", mk(1, 1, 1, 6, 32'h1000, 32'h55, 8, 32'h400, lw6));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(rtype(6, 0, 7, 6'h21), 32'h404, 1'b1, 32'h1, 32'h0);
    hold_in = 1'b1; flush_in = 1'b1; #1;
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL flush_masks_stall got=%b exp=0", stall_out); end
    push("flush_bubble", '0);
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    hold_in = 1'b0; flush_in = 1'b0;
    drive(x, 32'h408, 1'b1, 32'd5, 32'd7);
    push("hf_issue", mk(1, 1, 0, 3, 5, 7, 32'h1821, 32'h408, x));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(rtype(3, 3, 12, 6'h21), 32'h40C, 1'b1, 32'h9, 32'h9);
    hold_in = 1'b1; #1;
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL hold_stall got=%b exp=1", stall_out); end
    push("hold_retain", mk(1, 1, 0, 3, 5, 7, 32'h1821, 32'h408, x));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    hold_in = 1'b0; flush_in = 1'b1;
    push("flush_only", '0);
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    flush_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] i1, i2, i3;
    i1 = rtype(1, 2, 13, 6'h21);
    i2 = rtype(13, 13, 14, 6'h21);
    i3 = rtype(14, 13, 15, 6'h21);
    drive(i1, 32'h600, 1'b1, 32'd1, 32'd2);
    push("b2b_1", mk(1, 1, 0, 13, 1, 2, 32'h6821, 32'h600, i1));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(i2, 32'h604, 1'b1, 32'hBAD, 32'hBAD); alu_result = 32'h30;
    push("b2b_2", mk(1, 1, 0, 14, 32'h30, 32'h30, 32'h7021, 32'h604, i2));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(i3, 32'h608, 1'b1, 32'hBAD, 32'hBAD);
    alu_result = 32'h60; mem_d = 5'd13; mem_we = 1'b1; mem_data = 32'h30;
    push("b2b_3", mk(1, 1, 0, 15, 32'h60, 32'h30, 32'h7821, 32'h608, i3));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    mem_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] lw6, u;
    lw6 = itype(6'h23, 1, 6, 16'h0008);
    u   = rtype(6, 0, 7, 6'h21);
    #2; reset = 1'b1; hold_in = 1'b1; #1;
    checks++;
    if ({ex_valid, ex_we, ex_a} !== 34'h0) begin errors++; $display("FAIL async_reset got=%b/%b/%h exp=0/0/0", ex_valid, ex_we, ex_a); end
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL reset_hold_stall got=%b exp=1", stall_out); end
    hold_in = 1'b0; reset = 1'b0;
    @(posedge clock); #1;
    drive(lw6, 32'h500, 1'b1, 32'h1000, 32'h55);
    push("rm_lw", mk(1, 1, 1, 6, 32'h1000, 32'h55, 8, 32'h500, lw6));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
    drive(u, 32'h504, 1'b1, 32'h42, 32'h0); #1;
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL rm_stall got=%b exp=1", stall_out); end
    #2; reset = 1'b1; #1;
    checks++;
    if (pack_out() !== '0) begin errors++; $display("FAIL rm_cleared got=%h exp=0", pack_out()); end
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL rm_stall_dropped got=%b exp=0", stall_out); end
    reset = 1'b0;
    push("rm_issue", mk(1, 1, 0, 7, 32'h42, 0, 32'h3821, 32'h504, u));
    @(posedge clock); #1; e = sb.pop_front(); checks++;
    if (pack_out() !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, pack_out(), e.v); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_forward();
    test_load_use();
    test_imm();
    test_hold_flush();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
